// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI slave front-end.
// Contents: FSM state encoding (3-bit, idle = 0), frame command codes and a
// helper that classifies a command as read or write.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StChkCmd   = 3'd1,
    StWrite    = 3'd2,
    StReadAdd  = 3'd3,
    StReadData = 3'd4,
    StTxWait   = 3'd5,
    StTxShift  = 3'd6,
    StDone     = 3'd7
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Read commands share the MSB, so the first frame bit alone selects the read path.
  function automatic logic cmd_is_read(input logic [1:0] cmd);
    logic rd;
    case (cmd)
      CMD_WR_ADDR, CMD_WR_DATA: rd = 1'b0;
      CMD_RD_ADDR, CMD_RD_DATA: rd = 1'b1;
      default:                  rd = 1'b0;
    endcase
    return rd;
  endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// MISO serializer: loads a WORD_W read word and drives it MSB first, one bit per clk.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   load_i       capture data_i; its MSB is on miso_o from the next cycle
//   clear_i      abort any transfer, miso_o returns to 0
//   data_i       word to transmit
//   miso_o       registered serial output, 0 when idle
//   done_o       high while the last bit is on miso_o
module spi_tx_serializer #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              miso_o,
  output logic              done_o
);

  localparam int unsigned CntW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              active_q, active_d;
  logic              miso_q, miso_d;

  // cnt_q counts bits already placed on the line.
  assign done_o = active_q && (cnt_q == CntW'(WORD_W));
  assign miso_o = miso_q;

  always_comb begin
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    miso_d   = miso_q;
    if (clear_i) begin
      cnt_d    = '0;
      active_d = 1'b0;
      miso_d   = 1'b0;
    end else if (load_i) begin
      shreg_d  = data_i << 1;
      miso_d   = data_i[WORD_W-1];
      cnt_d    = CntW'(1);
      active_d = 1'b1;
    end else if (active_q) begin
      if (done_o) begin
        cnt_d    = '0;
        active_d = 1'b0;
        miso_d   = 1'b0;
      end else begin
        miso_d  = shreg_q[WORD_W-1];
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      miso_q   <= miso_d;
    end
  end

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front-end for the single-port RAM wrapper.
// Receives WORD_W+2 bit frames (2 command bits + payload) MSB first on MOSI, sampled on clk,
// and returns read data on MISO after a read-data frame. One frame per SS_n assertion.
// Optional macro SPI_PARITY_EN: each frame carries a trailing even-parity bit; a mismatch
// suppresses rx_valid and pulses frame_err instead.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   SS_n                slave select (active low, synchronous to clk)
//   MOSI / MISO         serial in / out, MSB first
//   rx_data, rx_valid   received frame and its one-cycle valid pulse
//   tx_data, tx_valid   read data from the memory controller, accepted while waiting to transmit
//   frame_err           one-cycle parity error pulse (0 when parity is disabled)
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [WORD_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err
);

  localparam int unsigned FRAME_W = WORD_W + 2;
  localparam int unsigned CNT_W   = $clog2(WORD_W + 3);
`ifdef SPI_PARITY_EN
  localparam int unsigned LastIdx = FRAME_W;      // parity bit follows the frame
`else
  localparam int unsigned LastIdx = FRAME_W - 1;
`endif

  spi_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rd_addr_seen_q, rd_addr_seen_d;

  logic rx_active, frame_end, frame_ok, tx_load, tx_done;

  // Bit-receiving states; a high SS_n overrides everything, including the last bit.
  assign rx_active = !SS_n && (state_q inside {StChkCmd, StWrite, StReadAdd, StReadData});
  assign frame_end = rx_active && (cnt_q == CNT_W'(LastIdx));
  assign tx_load   = !SS_n && (state_q == StTxWait) && tx_valid;

`ifdef SPI_PARITY_EN
  logic par_q, par_d, frame_err_q, frame_err_d;

  // par_q holds the XOR of frame bits so far; the parity bit must bring it to 0.
  assign frame_ok  = ~(par_q ^ MOSI);
  assign frame_err = frame_err_q;

  always_comb begin
    par_d       = 1'b0;
    frame_err_d = 1'b0;
    if (rx_active) par_d = par_q ^ MOSI;
    if (frame_end && !frame_ok) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      par_q       <= par_d;
      frame_err_q <= frame_err_d;
    end
  end
`else
  assign frame_ok  = 1'b1;
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (SS_n) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:   state_d = StChkCmd;
        StChkCmd: begin
          if (cmd_is_read({MOSI, 1'b0})) state_d = rd_addr_seen_q ? StReadData : StReadAdd;
          else                           state_d = StWrite;
        end
        StWrite, StReadAdd, StReadData: begin
          if (frame_end) state_d = (state_q == StReadData && frame_ok) ? StTxWait : StDone;
        end
        StTxWait:  if (tx_valid) state_d = StTxShift;
        StTxShift: if (tx_done) state_d = StDone;
        StDone:    state_d = StDone;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d          = '0;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    if (rx_active) begin
      cnt_d = cnt_q + 1'b1;
      for (int unsigned i = 0; i < FRAME_W; i++) begin
        if (cnt_q == CNT_W'(FRAME_W - 1 - i)) rx_data_d[i] = MOSI;
      end
    end
    if (frame_end && frame_ok) begin
      rx_valid_d = 1'b1;
      if (state_q == StReadAdd)       rd_addr_seen_d = 1'b1;
      else if (state_q == StReadData) rd_addr_seen_d = 1'b0;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  spi_tx_serializer #(
    .WORD_W(WORD_W)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tx_load),
    .clear_i(SS_n),
    .data_i (tx_data),
    .miso_o (MISO),
    .done_o (tx_done)
  );

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param with WORD_W = 8 (10-bit frames).
// Define SPI_PARITY_EN for both RTL and bench to exercise the parity build.
module tb_spi_slave_param;

  localparam int unsigned WORD_W  = 8;
  localparam int unsigned FRAME_W = WORD_W + 2;
`ifdef SPI_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = FRAME_W + PAR;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             SS_n = 1'b1;
  logic             MOSI = 1'b0;
  logic             MISO;
  logic [9:0]       rx_data;
  logic             rx_valid;
  logic [7:0]       tx_data = 8'h00;
  logic             tx_valid = 1'b0;
  logic             frame_err;

  spi_slave_param #(
    .WORD_W(WORD_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc, nv, vidx, nferr, nmiso, total_ferr;
  logic [9:0] vdata;
  logic [7:0] got;

  typedef struct {
    logic [9:0] frame;
    logic [9:0] exp_data;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; observe outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rx_valid === 1'b1) begin
      nv++;
      vidx  = cyc;
      vdata = rx_data;
    end
    if (frame_err === 1'b1) begin
      nferr++;
      total_ferr++;
    end
    if (MISO === 1'b1) nmiso++;
  endtask

  task automatic start_sel();
    SS_n  = 1'b0;
    MOSI  = 1'b0;
    cyc   = 0;
    nv    = 0;
    vidx  = -1;
    nferr = 0;
    nmiso = 0;
    tick();
  endtask

  // Drive bits[n-1] first.
  task automatic shift(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      MOSI = bits[i];
      tick();
    end
  endtask

  task automatic end_sel();
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic [31:0] with_par(input logic [9:0] f);
    if (PAR != 0) return {21'b0, f, ^f};
    else          return {22'b0, f};
  endfunction

  initial begin
    total_ferr = 0;
    vecs[0] = '{10'b00_1010_0101, 10'h0A5};
    vecs[1] = '{10'b01_0101_0101, 10'h155};
    vecs[2] = '{10'b00_0000_0000, 10'h000};
    vecs[3] = '{10'b01_1111_1111, 10'h1FF};
    vecs[4] = '{10'b00_1000_0001, 10'h081};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset MISO", 32'(MISO), 0);
    check("reset rx_data", 32'(rx_data), 0);
    check("reset rx_valid", 32'(rx_valid), 0);
    check("reset frame_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    tick();

    // Write frames from the table
    for (int k = 0; k < 5; k++) begin
      start_sel();
      shift(with_par(vecs[k].frame), FL);
      shift(32'h0, 3);  // DONE must ignore further bits
      end_sel();
      check($sformatf("vec%0d valid count", k), 32'(nv), 1);
      check($sformatf("vec%0d valid cycle", k), 32'(vidx), 32'(FL + 1));
      check($sformatf("vec%0d rx_data", k), 32'(vdata), 32'(vecs[k].exp_data));
      check($sformatf("vec%0d MISO quiet", k), 32'(nmiso), 0);
      check($sformatf("vec%0d frame_err", k), 32'(nferr), 0);
    end

    // Read address then read data with transmit
    start_sel();
    shift(with_par(10'b10_0000_0011), FL);
    end_sel();
    check("rd_addr valid", 32'(nv), 1);
    check("rd_addr data", 32'(vdata), 32'h203);

    start_sel();
    shift(with_par(10'b11_0000_0000), FL);
    check("rd_data valid", 32'(nv), 1);
    check("rd_data data", 32'(vdata), 32'h300);
    tick();
    tick();
    check("tx_wait MISO low", 32'(nmiso), 0);
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    got[7] = MISO;
    for (int b = 6; b >= 0; b--) begin
      tick();
      got[b] = MISO;
    end
    check("tx bits", 32'(got), 32'hC3);
    tick();
    check("tx MISO after word", 32'(MISO), 0);
    tick();
    check("tx MISO ones", 32'(nmiso), 4);
    end_sel();

    // rd_addr_seen is back to 0: a read frame now routes to READ_ADD, no transmit
    start_sel();
    shift(with_par(10'h2AA), FL);
    tick();
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    repeat (3) tick();
    check("after rd_data: no tx", 32'(nmiso), 0);
    check("after rd_data: valid", 32'(nv), 1);
    end_sel();

    // rd_addr_seen now set: read-data frame, then reset mid-transmit
    start_sel();
    shift(with_par(10'h3FF), FL);
    tick();
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    check("pre-reset MISO", 32'(MISO), 1);
    rst_n = 1'b0;
    #1;
    check("async reset MISO", 32'(MISO), 0);
    check("async reset rx_valid", 32'(rx_valid), 0);
    SS_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    start_sel();
    shift(with_par(10'h201), FL);
    tick();
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    repeat (3) tick();
    check("post-reset READ_ADD valid", 32'(nv), 1);
    check("post-reset no tx", 32'(nmiso), 0);
    end_sel();

    // Abort after 5 bits, then a full frame
    start_sel();
    shift(32'b01010, 5);
    end_sel();
    check("abort no valid", 32'(nv), 0);
    start_sel();
    shift(with_par(10'h155), FL);
    end_sel();
    check("after abort valid", 32'(nv), 1);
    check("after abort data", 32'(vdata), 32'h155);

    // SS_n rises together with the final bit
    start_sel();
    shift(with_par(10'h0F0) >> 1, FL - 1);
    MOSI = with_par(10'h0F0) & 32'h1 ? 1'b1 : 1'b0;
    SS_n = 1'b1;
    tick();
    tick();
    tick();
    check("late SS_n no valid", 32'(nv), 0);

    // 14 bits in one select window
    start_sel();
    shift((with_par(10'h0A5) << 4) | 32'hB, FL + 4);
    end_sel();
    check("extra bits valid", 32'(nv), 1);
    check("extra bits cycle", 32'(vidx), 32'(FL + 1));
    check("extra bits data", 32'(vdata), 32'h0A5);

`ifdef SPI_PARITY_EN
    start_sel();
    shift({21'b0, 10'h0A5, 1'b1}, 11);
    end_sel();
    check("bad parity no valid", 32'(nv), 0);
    check("bad parity frame_err", 32'(nferr), 1);
    start_sel();
    shift({21'b0, 10'h0A5, 1'b0}, 11);
    end_sel();
    check("good parity valid", 32'(nv), 1);
    check("good parity data", 32'(vdata), 32'h0A5);
    check("good parity frame_err", 32'(nferr), 0);
`else
    check("frame_err never set", 32'(total_ferr), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
